output_drain_ctrl: RTL

Sequencer for the output block of the systolic array. On a start pulse it captures the array's column results group by group: it loads the level-1 mux select, pulses the output-register write, then steps the level-2 select so that one column result is presented per accepted handshake. Unused columns are skipped. It sits between the layer controller (start/done) and the output block's select, load and register-control inputs, and drives a valid/ready stream to the writeback path.

---
 rtl/output_drain_ctrl_pkg.sv | 35 +++
 rtl/output_drain_ctrl_if.sv | 46 ++++
 rtl/output_drain_ctrl.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/output_drain_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Package : output_ctrl_pkg
// Brief   : Shared types and helpers for the output-block drain sequencer:
//           state encoding, default geometry and the column mapping rules.
// Rev     : 1.0 - initial release
// ============================================================================
package output_ctrl_pkg;

   localparam int c_DEFAULT_N_COLS      = 16;
   localparam int c_DEFAULT_N_MUX_OUT_1 = 4;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      LOAD    = 3'd1,
      CAPTURE = 3'd2,
      EMIT    = 3'd3,
      DONE    = 3'd4
   } state_t;

   // Column produced by level-1 select s (1-based) and level-2 select j.
   function automatic int col_of(input int s, input int j, input int nin);
      return j * nin + s - 1;
   endfunction

   // Number of level-2 positions j that map to a valid column for group s.
   function automatic int group_len(input int s, input int n_eff, input int nin);
      if ((s < 1) || (s > nin) || ((s - 1) >= n_eff)) begin
         return 0;
      end
      return (n_eff - s + nin) / nin;
   endfunction

endpackage
`default_nettype wire

// File: rtl/output_drain_ctrl_if.sv
`default_nettype none
// ============================================================================
// Interface : output_drain_ctrl_if
// Brief     : Control/stream bundle between the drain sequencer (master), the
//             layer controller, the output block and the writeback path.
// Rev       : 1.0 - initial release
// ============================================================================
interface output_drain_ctrl_if
   import output_ctrl_pkg::*;
#(
   parameter int N_COLS_ARRAY     = c_DEFAULT_N_COLS,
   parameter int NUMBER_MUX_OUT_1 = c_DEFAULT_N_MUX_OUT_1
);
   localparam int NUMBER_INPUT_MUX_OUT_1 = (N_COLS_ARRAY + NUMBER_MUX_OUT_1 - 1) / NUMBER_MUX_OUT_1;
   localparam int SEL_WIDTH_MUX_OUT_1    = $clog2(1 + NUMBER_INPUT_MUX_OUT_1);
   localparam int SEL_WIDTH_MUX_OUT_2    = $clog2(NUMBER_MUX_OUT_1);
   localparam int COL_WIDTH              = $clog2(N_COLS_ARRAY + 1);

   logic                           start_i;
   logic [COL_WIDTH-1:0]           n_cols_i;
   logic                           out_ready_i;
   logic [SEL_WIDTH_MUX_OUT_1-1:0] sel_mux_out_1_o;
   logic [SEL_WIDTH_MUX_OUT_2-1:0] sel_mux_out_2_o;
   logic                           sel_mux_ld_o;
   logic                           reg_wr_en_o;
   logic                           reg_rst_o;
   logic                           out_valid_o;
   logic [COL_WIDTH-1:0]           out_col_o;
   logic                           out_last_o;
   logic                           busy_o;
   logic                           done_o;

   modport master (
      input  start_i, n_cols_i, out_ready_i,
      output sel_mux_out_1_o, sel_mux_out_2_o, sel_mux_ld_o, reg_wr_en_o, reg_rst_o,
      output out_valid_o, out_col_o, out_last_o, busy_o, done_o
   );

   modport slave (
      output start_i, n_cols_i, out_ready_i,
      input  sel_mux_out_1_o, sel_mux_out_2_o, sel_mux_ld_o, reg_wr_en_o, reg_rst_o,
      input  out_valid_o, out_col_o, out_last_o, busy_o, done_o
   );

endinterface
`default_nettype wire

// File: rtl/output_drain_ctrl.sv
`default_nettype none
// ============================================================================
// Module : output_drain_ctrl
// Brief  : Drains the systolic array's column results through the two-level
//          output mux: loads the level-1 select, writes the output registers,
//          then steps the level-2 select once per accepted stream word.
// Rev    : 1.0 - initial release
// ============================================================================
module output_drain_ctrl
   import output_ctrl_pkg::*;
#(
   parameter int N_COLS_ARRAY     = c_DEFAULT_N_COLS,
   parameter int NUMBER_MUX_OUT_1 = c_DEFAULT_N_MUX_OUT_1
) (
   input  logic                clk_i,
   input  logic                sel_mux_rst_i,
   output_drain_ctrl_if.master bus
);

   localparam int NUMBER_INPUT_MUX_OUT_1 = (N_COLS_ARRAY + NUMBER_MUX_OUT_1 - 1) / NUMBER_MUX_OUT_1;
   localparam int SEL_WIDTH_MUX_OUT_1    = $clog2(1 + NUMBER_INPUT_MUX_OUT_1);
   localparam int SEL_WIDTH_MUX_OUT_2    = $clog2(NUMBER_MUX_OUT_1);
   localparam int COL_WIDTH              = $clog2(N_COLS_ARRAY + 1);

   state_t                         r_state,   nxt_state;
   logic [SEL_WIDTH_MUX_OUT_1-1:0] r_s,       nxt_s;
   logic [SEL_WIDTH_MUX_OUT_2-1:0] r_j,       nxt_j;
   logic [COL_WIDTH-1:0]           r_n_eff,   nxt_n_eff;
   logic [COL_WIDTH-1:0]           r_glen,    nxt_glen;
   logic [SEL_WIDTH_MUX_OUT_1-1:0] r_sel1,    nxt_sel1;
   logic [SEL_WIDTH_MUX_OUT_2-1:0] r_sel2,    nxt_sel2;
   logic [COL_WIDTH-1:0]           r_col,     nxt_col;
   logic                           r_last,    nxt_last;
   logic                           r_ld,      nxt_ld;
   logic                           r_wr_en,   nxt_wr_en;
   logic                           r_reg_rst, nxt_reg_rst;
   logic                           r_valid,   nxt_valid;
   logic                           r_done,    nxt_done;

   // The level-2 step must strobe in the accepting cycle so the output block's
   // select register advances on the same edge the word is consumed.
   logic                           w_emit_ld;
   logic [SEL_WIDTH_MUX_OUT_2-1:0] w_j_inc;

   // Next-state and next-output computation for the drain sequencer.
   always_comb begin
      int   v_s;
      int   v_j;
      int   v_n;
      int   v_glen;
      int   v_n_in;
      logic v_more_groups;

      nxt_state   = r_state;
      nxt_s       = r_s;
      nxt_j       = r_j;
      nxt_n_eff   = r_n_eff;
      nxt_glen    = r_glen;
      nxt_sel1    = r_sel1;
      nxt_sel2    = r_sel2;
      nxt_col     = r_col;
      nxt_last    = r_last;
      nxt_valid   = r_valid;
      nxt_ld      = 1'b0;
      nxt_wr_en   = 1'b0;
      nxt_reg_rst = 1'b0;
      nxt_done    = 1'b0;
      w_emit_ld   = 1'b0;

      v_s    = int'(r_s);
      v_j    = int'(r_j);
      v_n    = int'(r_n_eff);
      v_glen = int'(r_glen);
      v_n_in = int'(bus.n_cols_i);
      if (v_n_in > N_COLS_ARRAY) begin
         v_n_in = N_COLS_ARRAY;
      end
      w_j_inc = SEL_WIDTH_MUX_OUT_2'(v_j + 1);

      // Another group exists when the next level-1 input still maps to a column.
      v_more_groups = (v_s < NUMBER_INPUT_MUX_OUT_1) && (v_s < v_n);

      case (r_state)
         IDLE: begin
            if (bus.start_i) begin
               nxt_n_eff = COL_WIDTH'(v_n_in);
               nxt_s     = SEL_WIDTH_MUX_OUT_1'(1);
               nxt_j     = '0;
               if (v_n_in > 0) begin
                  nxt_state = LOAD;
                  nxt_glen  = COL_WIDTH'(group_len(1, v_n_in, NUMBER_INPUT_MUX_OUT_1));
                  nxt_ld    = 1'b1;
                  nxt_sel1  = SEL_WIDTH_MUX_OUT_1'(1);
                  nxt_sel2  = '0;
               end else begin
                  nxt_state   = DONE;
                  nxt_done    = 1'b1;
                  nxt_reg_rst = 1'b1;
               end
            end
         end
         LOAD: begin
            nxt_state = CAPTURE;
            nxt_wr_en = 1'b1;
         end
         CAPTURE: begin
            nxt_state = EMIT;
            nxt_valid = 1'b1;
            nxt_col   = COL_WIDTH'(col_of(v_s, 0, NUMBER_INPUT_MUX_OUT_1));
            nxt_last  = (v_glen == 1) && !v_more_groups;
         end
         EMIT: begin
            if (bus.out_ready_i) begin
               if ((v_j + 1) < v_glen) begin
                  w_emit_ld = 1'b1;
                  nxt_j     = w_j_inc;
                  nxt_sel2  = w_j_inc;
                  nxt_col   = COL_WIDTH'(col_of(v_s, v_j + 1, NUMBER_INPUT_MUX_OUT_1));
                  nxt_last  = ((v_j + 2) == v_glen) && !v_more_groups;
               end else if (v_more_groups) begin
                  nxt_state = LOAD;
                  nxt_s     = SEL_WIDTH_MUX_OUT_1'(v_s + 1);
                  nxt_j     = '0;
                  nxt_glen  = COL_WIDTH'(group_len(v_s + 1, v_n, NUMBER_INPUT_MUX_OUT_1));
                  nxt_ld    = 1'b1;
                  nxt_sel1  = SEL_WIDTH_MUX_OUT_1'(v_s + 1);
                  nxt_sel2  = '0;
                  nxt_valid = 1'b0;
                  nxt_last  = 1'b0;
               end else begin
                  nxt_state   = DONE;
                  nxt_valid   = 1'b0;
                  nxt_last    = 1'b0;
                  nxt_done    = 1'b1;
                  nxt_reg_rst = 1'b1;
               end
            end
         end
         DONE: begin
            nxt_state = IDLE;
         end
         default: begin
            nxt_state = IDLE;
         end
      endcase
   end

   // State, counters and registered outputs; async reset clears everything
   // so an aborted drain never produces a completion pulse.
   always_ff @(posedge clk_i or posedge sel_mux_rst_i) begin
      if (sel_mux_rst_i) begin
         r_state   <= IDLE;
         r_s       <= '0;
         r_j       <= '0;
         r_n_eff   <= '0;
         r_glen    <= '0;
         r_sel1    <= '0;
         r_sel2    <= '0;
         r_col     <= '0;
         r_last    <= 1'b0;
         r_ld      <= 1'b0;
         r_wr_en   <= 1'b0;
         r_reg_rst <= 1'b0;
         r_valid   <= 1'b0;
         r_done    <= 1'b0;
      end else begin
         r_state   <= nxt_state;
         r_s       <= nxt_s;
         r_j       <= nxt_j;
         r_n_eff   <= nxt_n_eff;
         r_glen    <= nxt_glen;
         r_sel1    <= nxt_sel1;
         r_sel2    <= nxt_sel2;
         r_col     <= nxt_col;
         r_last    <= nxt_last;
         r_ld      <= nxt_ld;
         r_wr_en   <= nxt_wr_en;
         r_reg_rst <= nxt_reg_rst;
         r_valid   <= nxt_valid;
         r_done    <= nxt_done;
      end
   end

   assign bus.sel_mux_ld_o    = r_ld | w_emit_ld;
   assign bus.sel_mux_out_1_o = r_sel1;
   assign bus.sel_mux_out_2_o = w_emit_ld ? w_j_inc : r_sel2;
   assign bus.reg_wr_en_o     = r_wr_en;
   assign bus.reg_rst_o       = r_reg_rst;
   assign bus.out_valid_o     = r_valid;
   assign bus.out_col_o       = r_col;
   assign bus.out_last_o      = r_last;
   assign bus.busy_o          = (r_state != IDLE);
   assign bus.done_o          = r_done;

endmodule
`default_nettype wire
